fp_addsub: RTL and testbench
============================

// Module: fp_addsub
// PURPOSE
//  Parametrised IEEE-754 binary floating-point adder/subtractor.
//  Successor to the fixed single-precision adder: adds a per-operation add/sub mode,
//  round-to-nearest-even, full subnormal support and exception flags.
//  Operands and result use the team's strobe/ack handshake (A and B channels, Z channel).
//  Instantiated by the FPU datapath; one operation in flight at a time.
// PARAMETERS
//  EXP_W  8   exponent field width. BIAS = 2^(EXP_W-1)-1.
//  MAN_W  23  stored fraction width, hidden bit excluded. Word width W = 1+EXP_W+MAN_W.
// PORTS
//  clk           in   1  single clock; all logic on the rising edge
//  rst           in   1  synchronous, active-high reset
//  input_a       in   W  operand A
//  input_a_stb   in   1  A valid
//  input_a_ack   out  1  A accepted; transfer when stb&ack
//  input_b       in   W  operand B
//  input_op      in   1  0 = A+B, 1 = A-B; sampled with B
//  input_b_stb   in   1  B valid
//  input_b_ack   out  1  B accepted
//  output_z      out  W  result
//  output_flags  out  4  {invalid, overflow, underflow, inexact}; valid with output_z_stb
//  output_z_stb  out  1  result valid
//  output_z_ack  in   1  consumer accepted Z
// BEHAVIOUR
//  Reset: state=GET_A. All outputs 0: acks, output_z_stb, output_z, output_flags.
//  rst mid-operation aborts the operation; no stb is emitted; the next A is taken fresh.
//  FSM: GET_A -> GET_B -> UNPACK -> SPECIAL -> ALIGN -> ADD -> NORM -> ROUND -> PACK -> PUT_Z -> GET_A.
//  GET_A: input_a_ack=1. On stb&ack, latch A, drop ack next cycle, go to GET_B. Same rules for B/op.
//  Latency: B handshake in cycle N -> output_z_stb=1 in cycle N+8.
//   A special case in SPECIAL jumps to PUT_Z -> output_z_stb=1 in cycle N+3.
//  PUT_Z: output_z/flags/stb held stable until output_z_ack=1. Then stb=0 next cycle and state=GET_A.
//   No ack is asserted while in PUT_Z.
//  UNPACK: exponent 0 -> subnormal; effective exponent 1, hidden bit 0.
//   Sub mode inverts B's sign. Mantissas are extended with guard, round and sticky bits.
//  SPECIAL (in priority order):
//   - Any NaN input, or inf plus opposite-signed inf -> canonical qNaN {0, all-ones exp, 1, 0...}, invalid=1.
//   - One inf -> that inf.
//   - Both zero -> -0 only if both effective signs are negative, else +0.
//  ALIGN: shift the smaller-exponent mantissa right by the exponent difference in one cycle (barrel).
//   Shifted-out bits OR into sticky. A difference >= MAN_W+3 leaves sticky only.
//  ADD: same signs add magnitudes (may carry). Opposite signs subtract smaller from larger.
//   The result sign is the sign of the larger magnitude.
//  NORM: on carry, shift right 1 (sticky kept) and exp+1.
//   Otherwise shift left by the leading-zero count from fp_lzc, clamped so exp does not go below 1.
//   Stopping at exp 1 produces the subnormal result.
//  ROUND: RNE. Increment when g & (r | s | lsb). inexact = g|r|s.
//   A mantissa overflow from rounding renormalises and exp+1.
//  PACK:
//   - exp >= 2^EXP_W-1 -> signed inf, overflow=1, inexact=1.
//   - Hidden bit 0 after round -> exp field 0; underflow=1 iff inexact.
//   - Exact cancellation (x-x) -> +0.
// STRUCTURE
//  Package fp_pkg:
//   - state enum: GET_A, GET_B, UNPACK, SPECIAL, ALIGN, ADD, NORM, ROUND, PACK, PUT_Z
//   - localparams W, BIAS, EXP_MAX, FLAG_* bit indices
//   - canonical-NaN constant function
//  One sub-module: fp_lzc #(WIDTH). A combinational leading-zero counter used in NORM.
//  Everything else stays in fp_addsub. Target 250-350 lines.
// TESTING (default params unless noted; flags shown as {inv,ovf,unf,inx})
//  1. 0x417C0000 (15.75) + 0x40E80000 (7.25), op=0 -> 0x41B80000 (23.0), flags 0000, stb at N+8.
//  2. Same operands, op=1 -> 0x41080000 (8.5). Then 0x417C0000 - 0x417C0000 -> 0x00000000, flags 0000.
//  3. 0x7F800000 - 0x7F800000 -> 0x7FC00000, invalid=1, stb at N+3.
//     0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, flags 0101.
//  4. Rounding and subnormals:
//     - 0x3F800000 + 0x33800000 (tie) -> 0x3F800000, inexact=1.
//     - 0x00000001 + 0x00000001 -> 0x00000002, flags 0000.
//     - 0x00800000 - 0x00000001 -> 0x007FFFFF.
//  5. Handshake/reset:
//     - Hold output_z_ack=0 for 5 cycles -> output_z and stb stable; acks stay 0.
//     - Assert rst in ALIGN -> all outputs 0 next cycle; no stb; next op correct.
//  6. EXP_W=5, MAN_W=10: 0x3C00 + 0x3C00 -> 0x4000; 0x7BFF + 0x7BFF -> 0x7C00, flags 0101.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point add/subtract block.
//  - Default-format widths and derived constants (W, BIAS, EXP_MAX)
//  - Bit positions inside the 4-bit exception flag vector
//  - FSM state encoding (fixed localparam codes wrapped in an enum)
//  - canon_nan(): builds the canonical quiet NaN for any exponent/fraction width
package fp_pkg;

    localparam int DEF_EXP_W = 8;
    localparam int DEF_MAN_W = 23;
    localparam int W         = 1 + DEF_EXP_W + DEF_MAN_W;
    localparam int BIAS      = (1 << (DEF_EXP_W - 1)) - 1;
    localparam int EXP_MAX   = (1 << DEF_EXP_W) - 1;

    // Flag vector layout: {invalid, overflow, underflow, inexact}
    localparam int FLAG_INX = 0;
    localparam int FLAG_UNF = 1;
    localparam int FLAG_OVF = 2;
    localparam int FLAG_INV = 3;

    // Fixed state codes, kept stable so older trace tooling still decodes them
    localparam logic [3:0] S_GET_A   = 4'd0;
    localparam logic [3:0] S_GET_B   = 4'd1;
    localparam logic [3:0] S_UNPACK  = 4'd2;
    localparam logic [3:0] S_SPECIAL = 4'd3;
    localparam logic [3:0] S_ALIGN   = 4'd4;
    localparam logic [3:0] S_ADD     = 4'd5;
    localparam logic [3:0] S_NORM    = 4'd6;
    localparam logic [3:0] S_ROUND   = 4'd7;
    localparam logic [3:0] S_PACK    = 4'd8;
    localparam logic [3:0] S_PUT_Z   = 4'd9;

    typedef enum logic [3:0] {
        GET_A   = S_GET_A,
        GET_B   = S_GET_B,
        UNPACK  = S_UNPACK,
        SPECIAL = S_SPECIAL,
        ALIGN   = S_ALIGN,
        ADD     = S_ADD,
        NORM    = S_NORM,
        ROUND   = S_ROUND,
        PACK    = S_PACK,
        PUT_Z   = S_PUT_Z
    } state_t;

    // Canonical qNaN: sign 0, exponent all ones, fraction MSB set, rest zero.
    // Returned right-aligned in 64 bits; callers truncate to their word width.
    function automatic logic [63:0] canon_nan(input int exp_w, input int man_w);
        logic [63:0] ones;
        ones = (64'd1 << (exp_w + 1)) - 64'd1;
        return ones << (man_w - 1);
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter.
//  value : WIDTH-bit input vector
//  count : number of zeros above the most significant set bit (WIDTH when value is 0)
module fp_lzc #(
    parameter int WIDTH = 27,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] value,
    output logic [CW-1:0]    count
);

    // Scan upward; the highest set bit is visited last and therefore wins
    always_comb begin
        count = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            count = value[i] ? CW'(WIDTH - 1 - i) : count;
        end
    end

endmodule

// File: rtl/fp_addsub.sv
// IEEE-754 binary floating-point adder/subtractor, one operation in flight.
//  clk, rst          : single clock, synchronous active-high reset
//  input_a/_stb/_ack : operand A channel (transfer on stb & ack)
//  input_b/_op/_stb/_ack : operand B channel; op 0 = A+B, 1 = A-B, sampled with B
//  output_z/_flags/_stb/_ack : result channel; flags = {invalid, overflow, underflow, inexact}
// Round-to-nearest-even, full subnormal support. Result appears 8 cycles after the
// B handshake, or 3 cycles for NaN/infinity/zero special cases.
module fp_addsub
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [EXP_W+MAN_W:0]   input_a,
    input  logic                   input_a_stb,
    output logic                   input_a_ack,
    input  logic [EXP_W+MAN_W:0]   input_b,
    input  logic                   input_op,
    input  logic                   input_b_stb,
    output logic                   input_b_ack,
    output logic [EXP_W+MAN_W:0]   output_z,
    output logic [3:0]             output_flags,
    output logic                   output_z_stb,
    input  logic                   output_z_ack
);

    localparam int WD = 1 + EXP_W + MAN_W;
    localparam int MW = MAN_W + 4;           // hidden + fraction + guard/round/sticky
    localparam int SW = MW + 1;              // room for the addition carry
    localparam int EW = EXP_W + 2;           // headroom for exponent increments
    localparam int CW = $clog2(MW + 1);

    localparam logic [EW-1:0] E_ONE = EW'(1);
    localparam logic [EW-1:0] E_TOP = EW'((1 << EXP_W) - 1);
    localparam logic [EW-1:0] E_FAR = EW'(MAN_W + 3);
    localparam logic [WD-1:0] QNAN  = WD'(canon_nan(EXP_W, MAN_W));

    state_t           state_r;
    logic [WD-1:0]    a_r, b_r;
    logic             op_r;
    logic             a_s_r, b_s_r, z_s_r;
    logic [EW-1:0]    a_e_r, b_e_r, z_e_r;
    logic [MW-1:0]    a_m_r, b_m_r, z_m_r;
    logic [SW-1:0]    sum_r;
    logic [MAN_W:0]   rnd_m_r;
    logic             inexact_r;

    // Raw field views of the latched operands
    logic [EXP_W-1:0] a_exp_s, b_exp_s;
    logic [MAN_W-1:0] a_frac_s, b_frac_s;
    assign a_exp_s  = a_r[WD-2:MAN_W];
    assign b_exp_s  = b_r[WD-2:MAN_W];
    assign a_frac_s = a_r[MAN_W-1:0];
    assign b_frac_s = b_r[MAN_W-1:0];

    // Operand classification and special-case result selection
    logic          a_nan_s, b_nan_s, a_inf_s, b_inf_s, a_zero_s, b_zero_s;
    logic          spec_hit_s;
    logic [WD-1:0] spec_z_s;
    logic [3:0]    spec_flags_s;
    always_comb begin
        a_nan_s  = (&a_exp_s) & (|a_frac_s);
        b_nan_s  = (&b_exp_s) & (|b_frac_s);
        a_inf_s  = (&a_exp_s) & ~(|a_frac_s);
        b_inf_s  = (&b_exp_s) & ~(|b_frac_s);
        a_zero_s = ~(|a_exp_s) & ~(|a_frac_s);
        b_zero_s = ~(|b_exp_s) & ~(|b_frac_s);
        spec_hit_s   = 1'b1;
        spec_z_s     = '0;
        spec_flags_s = 4'b0000;
        if (a_nan_s || b_nan_s || (a_inf_s && b_inf_s && (a_s_r != b_s_r))) begin
            spec_z_s               = QNAN;
            spec_flags_s[FLAG_INV] = 1'b1;
        end else if (a_inf_s) begin
            spec_z_s = {a_s_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (b_inf_s) begin
            spec_z_s = {b_s_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (a_zero_s && b_zero_s) begin
            // Signs here are effective (B already flipped for subtraction)
            spec_z_s = {a_s_r & b_s_r, {(WD-1){1'b0}}};
        end else begin
            spec_hit_s = 1'b0;
        end
    end

    // Barrel alignment of the smaller-exponent mantissa, folding lost bits into sticky
    logic          a_big_s;
    logic [EW-1:0] diff_s, big_e_s;
    logic [MW-1:0] small_m_s, aligned_m_s;
    logic          lost_s;
    always_comb begin
        a_big_s = (a_e_r > b_e_r);
        if (a_big_s) begin
            diff_s    = a_e_r - b_e_r;
            small_m_s = b_m_r;
            big_e_s   = a_e_r;
        end else begin
            diff_s    = b_e_r - a_e_r;
            small_m_s = a_m_r;
            big_e_s   = b_e_r;
        end
        lost_s = 1'b0;
        if (diff_s >= E_FAR) begin
            aligned_m_s = {{(MW-1){1'b0}}, |small_m_s};
        end else begin
            lost_s      = |(small_m_s & ~({MW{1'b1}} << diff_s));
            aligned_m_s = (small_m_s >> diff_s) | {{(MW-1){1'b0}}, lost_s};
        end
    end

    // Magnitude add/subtract; an exactly zero difference is forced to +0
    logic [SW-1:0] add_sum_s;
    logic          add_sgn_raw_s, add_sgn_s;
    always_comb begin
        if (a_s_r == b_s_r) begin
            add_sum_s     = {1'b0, a_m_r} + {1'b0, b_m_r};
            add_sgn_raw_s = a_s_r;
        end else if (a_m_r >= b_m_r) begin
            add_sum_s     = {1'b0, a_m_r - b_m_r};
            add_sgn_raw_s = a_s_r;
        end else begin
            add_sum_s     = {1'b0, b_m_r - a_m_r};
            add_sgn_raw_s = b_s_r;
        end
        add_sgn_s = (add_sum_s == '0) ? 1'b0 : add_sgn_raw_s;
    end

    logic [CW-1:0] lz_s;
    fp_lzc #(.WIDTH(MW), .CW(CW)) u_lzc (
        .value (sum_r[MW-1:0]),
        .count (lz_s)
    );

    // Normalisation: carry shifts right, otherwise left by lzc but never below exp 1
    logic [MW-1:0] norm_m_s;
    logic [EW-1:0] norm_e_s, norm_sh_s, e_room_s;
    always_comb begin
        e_room_s = z_e_r - E_ONE;
        if (sum_r[SW-1]) begin
            norm_sh_s = '0;
            norm_m_s  = {sum_r[SW-1:2], sum_r[1] | sum_r[0]};
            norm_e_s  = z_e_r + E_ONE;
        end else begin
            norm_sh_s = (EW'(lz_s) < e_room_s) ? EW'(lz_s) : e_room_s;
            norm_m_s  = sum_r[MW-1:0] << norm_sh_s;
            norm_e_s  = z_e_r - norm_sh_s;
        end
    end

    // Round to nearest, ties to even; a carry out of the mantissa bumps the exponent
    logic           g_s, r_s, st_s, lsb_s, inc_s, rnd_inx_s;
    logic [MAN_W+1:0] rnd_sum_s;
    logic [MAN_W:0] rnd_m_s;
    logic [EW-1:0]  rnd_e_s;
    always_comb begin
        lsb_s     = z_m_r[3];
        g_s       = z_m_r[2];
        r_s       = z_m_r[1];
        st_s      = z_m_r[0];
        inc_s     = g_s & (r_s | st_s | lsb_s);
        rnd_inx_s = g_s | r_s | st_s;
        rnd_sum_s = {1'b0, z_m_r[MW-1:3]} + {{(MAN_W+1){1'b0}}, inc_s};
        if (rnd_sum_s[MAN_W+1]) begin
            rnd_m_s = rnd_sum_s[MAN_W+1:1];
            rnd_e_s = z_e_r + E_ONE;
        end else begin
            rnd_m_s = rnd_sum_s[MAN_W:0];
            rnd_e_s = z_e_r;
        end
    end

    // Final encoding: overflow to infinity, subnormal/zero, or normal
    logic [WD-1:0] pack_z_s;
    logic [3:0]    pack_flags_s;
    always_comb begin
        pack_flags_s = 4'b0000;
        if (z_e_r >= E_TOP) begin
            pack_z_s               = {z_s_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            pack_flags_s[FLAG_OVF] = 1'b1;
            pack_flags_s[FLAG_INX] = 1'b1;
        end else if (!rnd_m_r[MAN_W]) begin
            pack_z_s               = {z_s_r, {EXP_W{1'b0}}, rnd_m_r[MAN_W-1:0]};
            pack_flags_s[FLAG_UNF] = inexact_r;
            pack_flags_s[FLAG_INX] = inexact_r;
        end else begin
            pack_z_s               = {z_s_r, z_e_r[EXP_W-1:0], rnd_m_r[MAN_W-1:0]};
            pack_flags_s[FLAG_INX] = inexact_r;
        end
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= GET_A;
            input_a_ack  <= 1'b0;
            input_b_ack  <= 1'b0;
            output_z     <= '0;
            output_flags <= 4'b0000;
            output_z_stb <= 1'b0;
            a_r          <= '0;
            b_r          <= '0;
            op_r         <= 1'b0;
            a_s_r        <= 1'b0;
            b_s_r        <= 1'b0;
            z_s_r        <= 1'b0;
            a_e_r        <= '0;
            b_e_r        <= '0;
            z_e_r        <= '0;
            a_m_r        <= '0;
            b_m_r        <= '0;
            z_m_r        <= '0;
            sum_r        <= '0;
            rnd_m_r      <= '0;
            inexact_r    <= 1'b0;
        end else begin
            case (state_r)
                GET_A: begin
                    if (input_a_ack && input_a_stb) begin
                        a_r         <= input_a;
                        input_a_ack <= 1'b0;
                        state_r     <= GET_B;
                    end else begin
                        input_a_ack <= 1'b1;
                    end
                end
                GET_B: begin
                    if (input_b_ack && input_b_stb) begin
                        b_r         <= input_b;
                        op_r        <= input_op;
                        input_b_ack <= 1'b0;
                        state_r     <= UNPACK;
                    end else begin
                        input_b_ack <= 1'b1;
                    end
                end
                UNPACK: begin
                    // Subnormals use effective exponent 1 with a clear hidden bit
                    a_s_r   <= a_r[WD-1];
                    b_s_r   <= b_r[WD-1] ^ op_r;
                    a_e_r   <= (a_exp_s == '0) ? E_ONE : {2'b00, a_exp_s};
                    b_e_r   <= (b_exp_s == '0) ? E_ONE : {2'b00, b_exp_s};
                    a_m_r   <= {|a_exp_s, a_frac_s, 3'b000};
                    b_m_r   <= {|b_exp_s, b_frac_s, 3'b000};
                    state_r <= SPECIAL;
                end
                SPECIAL: begin
                    if (spec_hit_s) begin
                        output_z     <= spec_z_s;
                        output_flags <= spec_flags_s;
                        output_z_stb <= 1'b1;
                        state_r      <= PUT_Z;
                    end else begin
                        state_r <= ALIGN;
                    end
                end
                ALIGN: begin
                    if (a_big_s) begin
                        b_m_r <= aligned_m_s;
                    end else begin
                        a_m_r <= aligned_m_s;
                    end
                    z_e_r   <= big_e_s;
                    state_r <= ADD;
                end
                ADD: begin
                    sum_r   <= add_sum_s;
                    z_s_r   <= add_sgn_s;
                    state_r <= NORM;
                end
                NORM: begin
                    z_m_r   <= norm_m_s;
                    z_e_r   <= norm_e_s;
                    state_r <= ROUND;
                end
                ROUND: begin
                    rnd_m_r   <= rnd_m_s;
                    z_e_r     <= rnd_e_s;
                    inexact_r <= rnd_inx_s;
                    state_r   <= PACK;
                end
                PACK: begin
                    output_z     <= pack_z_s;
                    output_flags <= pack_flags_s;
                    output_z_stb <= 1'b1;
                    state_r      <= PUT_Z;
                end
                PUT_Z: begin
                    if (output_z_ack) begin
                        output_z_stb <= 1'b0;
                        state_r      <= GET_A;
                    end else begin
                        output_z_stb <= 1'b1;
                    end
                end
                default: begin
                    state_r <= GET_A;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_addsub.sv
// Scoreboard bench for fp_addsub: the driver pushes hand-computed results, a
// monitor pops and compares whenever a result strobe appears.
module tb_fp_addsub;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a, b, z;
    logic        op, a_stb, a_ack, b_stb, b_ack, z_stb, z_ack;
    logic [3:0]  flags;
    logic [15:0] ha, hb, hz;
    logic        hop, ha_stb, ha_ack, hb_stb, hb_ack, hz_stb, hz_ack;
    logic [3:0]  hflags;

    always #5 clk = ~clk;

    fp_addsub dut (
        .clk(clk), .rst(rst),
        .input_a(a), .input_a_stb(a_stb), .input_a_ack(a_ack),
        .input_b(b), .input_op(op), .input_b_stb(b_stb), .input_b_ack(b_ack),
        .output_z(z), .output_flags(flags), .output_z_stb(z_stb), .output_z_ack(z_ack)
    );

    fp_addsub #(.EXP_W(5), .MAN_W(10)) dut_h (
        .clk(clk), .rst(rst),
        .input_a(ha), .input_a_stb(ha_stb), .input_a_ack(ha_ack),
        .input_b(hb), .input_op(hop), .input_b_stb(hb_stb), .input_b_ack(hb_ack),
        .output_z(hz), .output_flags(hflags), .output_z_stb(hz_stb), .output_z_ack(hz_ack)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int hs_cyc  = 0;
    int hold_req = 0;

    logic [31:0] q_z[$];
    logic [3:0]  q_f[$];
    int          q_lat[$];
    logic [15:0] hq_z[$];
    logic [3:0]  hq_f[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag_error(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Main monitor: compares fresh results, then checks stability while the strobe is held
    initial begin
        logic        seen;
        logic [31:0] held_z, ez;
        logic [3:0]  held_f, ef;
        int          el;
        seen = 1'b0;
        held_z = '0;
        held_f = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                seen = 1'b0;
            end else if (z_stb && !seen) begin
                seen = 1'b1;
                held_z = z;
                held_f = flags;
                if (q_z.size() == 0) begin
                    flag_error("unexpected_z_stb");
                end else begin
                    ez = q_z.pop_front();
                    ef = q_f.pop_front();
                    el = q_lat.pop_front();
                    check("z", 64'(z), 64'(ez));
                    check("flags", 64'(flags), 64'(ef));
                    check("latency", 64'(cyc - hs_cyc), 64'(el - 1));
                end
                check("acks_low", 64'({a_ack, b_ack}), 64'(0));
            end else if (z_stb) begin
                check("z_stable", 64'({z, flags}), 64'({held_z, held_f}));
                check("acks_low_hold", 64'({a_ack, b_ack}), 64'(0));
            end else begin
                seen = 1'b0;
            end
        end
    end

    // Consumer: acknowledges after hold_req cycles of strobe
    initial begin
        int hold_cnt;
        hold_cnt = 0;
        z_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (z_stb && !rst) begin
                hold_cnt++;
                z_ack = (hold_cnt > hold_req);
            end else begin
                hold_cnt = 0;
                z_ack = 1'b0;
            end
        end
    end

    // Half-precision monitor; its consumer always accepts immediately
    initial begin
        logic [15:0] ez;
        logic [3:0]  ef;
        forever begin
            @(negedge clk);
            if (hz_stb && !rst) begin
                if (hq_z.size() == 0) begin
                    flag_error("unexpected_hz_stb");
                end else begin
                    ez = hq_z.pop_front();
                    ef = hq_f.pop_front();
                    check("hz", 64'(hz), 64'(ez));
                    check("hflags", 64'(hflags), 64'(ef));
                end
            end
        end
    end

    task automatic send(input logic [31:0] va, input logic [31:0] vb, input logic vop);
        int t;
        @(negedge clk);
        a = va;
        a_stb = 1'b1;
        t = 0;
        while (!a_ack && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) flag_error("timeout_a_ack");
        @(posedge clk);
        #1 a_stb = 1'b0;
        @(negedge clk);
        b = vb;
        op = vop;
        b_stb = 1'b1;
        t = 0;
        while (!b_ack && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) flag_error("timeout_b_ack");
        @(posedge clk);
        #1 b_stb = 1'b0;
        hs_cyc = cyc;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        @(negedge clk);
        while ((q_z.size() != 0 || z_stb) && t < 100) begin @(negedge clk); t++; end
        if (t >= 100) flag_error("timeout_result");
    endtask

    task automatic do_op(input logic [31:0] va, input logic [31:0] vb, input logic vop,
                         input logic [31:0] ez, input logic [3:0] ef, input int lat);
        q_z.push_back(ez);
        q_f.push_back(ef);
        q_lat.push_back(lat);
        send(va, vb, vop);
        wait_done();
    endtask

    task automatic h_op(input logic [15:0] va, input logic [15:0] vb, input logic vop,
                        input logic [15:0] ez, input logic [3:0] ef);
        int t;
        hq_z.push_back(ez);
        hq_f.push_back(ef);
        @(negedge clk);
        ha = va;
        ha_stb = 1'b1;
        t = 0;
        while (!ha_ack && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) flag_error("timeout_ha_ack");
        @(posedge clk);
        #1 ha_stb = 1'b0;
        @(negedge clk);
        hb = vb;
        hop = vop;
        hb_stb = 1'b1;
        t = 0;
        while (!hb_ack && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) flag_error("timeout_hb_ack");
        @(posedge clk);
        #1 hb_stb = 1'b0;
        t = 0;
        @(negedge clk);
        while ((hq_z.size() != 0 || hz_stb) && t < 100) begin @(negedge clk); t++; end
        if (t >= 100) flag_error("timeout_h_result");
    endtask

    initial begin
        int stb_count;
        rst = 1'b1;
        a = '0; b = '0; op = 1'b0; a_stb = 1'b0; b_stb = 1'b0;
        ha = '0; hb = '0; hop = 1'b0; ha_stb = 1'b0; hb_stb = 1'b0; hz_ack = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({z_stb, a_ack, b_ack, flags, z}), 64'(0));
        check("reset_outputs_h", 64'({hz_stb, ha_ack, hb_ack, hflags, hz}), 64'(0));
        rst = 1'b0;

        // {inv, ovf, unf, inx}
        do_op(32'h417C0000, 32'h40E80000, 1'b0, 32'h41B80000, 4'b0000, 8);
        do_op(32'h417C0000, 32'h40E80000, 1'b1, 32'h41080000, 4'b0000, 8);
        do_op(32'h417C0000, 32'h417C0000, 1'b1, 32'h00000000, 4'b0000, 8);
        do_op(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000, 3);
        do_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101, 8);
        do_op(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001, 8);
        do_op(32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 4'b0000, 8);
        do_op(32'h00800000, 32'h00000001, 1'b1, 32'h007FFFFF, 4'b0000, 8);
        do_op(32'h3F800000, 32'h33800000, 1'b1, 32'h3F7FFFFF, 4'b0000, 8);
        do_op(32'h3F800000, 32'h00000001, 1'b0, 32'h3F800000, 4'b0001, 8);
        do_op(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000, 3);
        do_op(32'h80000000, 32'h00000000, 1'b0, 32'h00000000, 4'b0000, 3);
        do_op(32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000, 3);
        do_op(32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 4'b0000, 3);

        // Consumer stalls: result must stay stable with no acks for 5 cycles
        hold_req = 5;
        do_op(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000, 8);
        hold_req = 0;

        // Reset during ALIGN aborts the operation
        send(32'h417C0000, 32'h40E80000, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_outputs", 64'({z_stb, a_ack, b_ack, flags, z}), 64'(0));
        rst = 1'b0;
        stb_count = 0;
        repeat (12) begin
            @(negedge clk);
            if (z_stb) stb_count++;
        end
        check("rst_no_stb", 64'(stb_count), 64'(0));
        do_op(32'h417C0000, 32'h40E80000, 1'b0, 32'h41B80000, 4'b0000, 8);

        // Half precision
        h_op(16'h3C00, 16'h3C00, 1'b0, 16'h4000, 4'b0000);
        h_op(16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 4'b0101);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
